// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the serial instruction-memory loader.
// Holds the loader state enum, the frame sync byte and the frame-field widths.
// Build option: IMEM_LOADER_CHECKSUM_EN adds the CSUM state (checksum byte at frame end).
package imem_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/imem_loader_word_pack.sv
// loader_word_pack: assembles four consecutive bytes into a little-endian 32-bit word.
// Ports:
//   clk, reset      clock, async active-low reset
//   clear_i         hold the byte counter at zero (outside the payload phase)
//   byte_en_i       byte_i is consumed this cycle
//   byte_i          incoming payload byte
//   word_o_c        assembled word, valid together with full_o_c
//   full_o_c        the byte consumed this cycle completes a word
module loader_word_pack
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o_c,
    output logic              full_o_c
);

    logic [1:0]  cnt_q;
    logic [23:0] data_q;

    // Bytes shift in from the top so the first byte ends up in bits 7:0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= 2'd0;
            data_q <= 24'd0;
        end else if (clear_i) begin
            cnt_q  <= 2'd0;
        end else if (byte_en_i) begin
            cnt_q  <= cnt_q + 2'd1;
            data_q <= {byte_i, data_q[23:8]};
        end
    end

    assign word_o_c = {byte_i, data_q};
    assign full_o_c = byte_en_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream and writes it into instruction memory,
// holding the CPU in reset until a complete, valid image has been loaded.
// Frame: A5, count_lo, count_hi, 4*N payload bytes [, checksum byte].
// Ports:
//   clk, reset                    clock, async active-low reset
//   rx_data, rx_valid, rx_ready   byte stream handshake
//   im_we, im_addr, im_wdata      instruction-memory write port (one-cycle strobe per word)
//   cpu_hold, done, error         load status
// Build option: IMEM_LOADER_CHECKSUM_EN enables the trailing checksum byte and its check.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       IMEM_DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR        = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned IDX_W = (IMEM_DEPTH_WORDS > 1) ? $clog2(IMEM_DEPTH_WORDS) : 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e S_END = S_CSUM;
`else
    localparam state_e S_END = S_DONE;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               rx_ready_q;
    logic               im_we_q, im_we_d;
    logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
    logic [WORD_W-1:0]  im_wdata_q, im_wdata_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  csum_q, csum_d;
`endif

    logic               hs_c;
    logic [CNT_W-1:0]   n_c;
    logic               last_word_c;
    logic [WORD_W-1:0]  word_c;
    logic               word_full_c;

    assign hs_c        = rx_valid && rx_ready_q;
    assign n_c         = {rx_data, cnt_q[BYTE_W-1:0]};
    assign last_word_c = (32'(idx_q) == (32'(cnt_q) - 32'd1));

    loader_word_pack u_word_pack (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q != S_DATA),
        .byte_en_i (hs_c && (state_q == S_DATA)),
        .byte_i    (rx_data),
        .word_o_c  (word_c),
        .full_o_c  (word_full_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        if (hs_c) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = S_CNT_LO;
                        idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                S_CNT_LO: begin
                    cnt_d   = CNT_W'(rx_data);
                    state_d = S_CNT_HI;
                end
                S_CNT_HI: begin
                    cnt_d = n_c;
                    if (n_c == '0) begin
                        state_d = S_END;
                    end else if (32'(n_c) > IMEM_DEPTH_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                end
                S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q + rx_data;
`endif
                    if (word_full_c) begin
                        im_we_d    = 1'b1;
                        im_addr_d  = BASE_ADDR + (32'(idx_q) << 2);
                        im_wdata_d = word_c;
                        // Index stays on the last word so it never reaches the depth.
                        if (last_word_c) begin
                            state_d = S_END;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
        // Status flags track the state they will accompany.
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            rx_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= BASE_ADDR;
            im_wdata_q <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rx_ready_q <= 1'b1;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign rx_ready = rx_ready_q;
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames with hand-computed expected writes and status.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    int          we_cnt = 0;
    logic [31:0] addr_log [0:15];
    logic [31:0] data_log [0:15];

    imem_loader #(.IMEM_DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Write monitor: record every strobe seen mid-cycle.
    always @(negedge clk) begin
        if (im_we) begin
            if (we_cnt < 16) begin
                addr_log[we_cnt] = im_addr;
                data_log[we_cnt] = im_wdata;
            end
            we_cnt = we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int waited;
        waited = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        while (!rx_ready && waited < 16) begin
            @(posedge clk);
            waited++;
        end
        if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        #1 rx_valid = 1'b0;
        if (gap) @(posedge clk);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    int base;

    initial begin
        // Reset values
        #12;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_im_we",    32'(im_we),    32'd0);
        check("rst_im_addr",  im_addr,       32'h0);
        check("rst_im_wdata", im_wdata,      32'h0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done",     32'(done),     32'd0);
        check("rst_error",    32'(error),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rx_ready_after_rst", 32'(rx_ready), 32'd1);

        // Single-word frame
        base = we_cnt;
        send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
        send(8'h13, 0); send(8'h05, 0); send(8'h10, 0); send(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h28, 0);
`endif
        settle();
        check("a_writes",   32'(we_cnt - base), 32'd1);
        check("a_addr",     addr_log[base],     32'h0000_0000);
        check("a_wdata",    data_log[base],     32'h0010_0513);
        check("a_done",     32'(done),          32'd1);
        check("a_cpu_hold", 32'(cpu_hold),      32'd0);
        check("a_error",    32'(error),         32'd0);

        // Restart from DONE; gapped valid with 0xA5 inside the payload
        base = we_cnt;
        send(8'hA5, 1);
        settle();
        check("b_restart_hold", 32'(cpu_hold), 32'd1);
        check("b_restart_done", 32'(done),     32'd0);
        send(8'h02, 1); send(8'h00, 1);
        send(8'hA5, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
        send(8'h44, 1); send(8'hA5, 1); send(8'h66, 1); send(8'h77, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'hD1, 1);
`endif
        settle();
        check("b_writes", 32'(we_cnt - base), 32'd2);
        check("b_addr0",  addr_log[base],     32'h0000_0000);
        check("b_data0",  data_log[base],     32'h3322_11A5);
        check("b_addr1",  addr_log[base+1],   32'h0000_0004);
        check("b_data1",  data_log[base+1],   32'h7766_A544);
        check("b_done",   32'(done),          32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Two words, bad checksum
        base = we_cnt;
        send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 0);
        send(8'h25, 0);
        settle();
        check("c_writes",   32'(we_cnt - base), 32'd2);
        check("c_addr0",    addr_log[base],     32'h0000_0000);
        check("c_data0",    data_log[base],     32'h0403_0201);
        check("c_addr1",    addr_log[base+1],   32'h0000_0004);
        check("c_data1",    data_log[base+1],   32'h0807_0605);
        check("c_error",    32'(error),         32'd1);
        check("c_cpu_hold", 32'(cpu_hold),      32'd1);
        check("c_done",     32'(done),          32'd0);
        send(8'h00, 0);
        settle();
        check("c_error_sticky", 32'(error), 32'd1);
`else
        // No checksum byte: the byte after the last word is ignored in DONE
        base = we_cnt;
        send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
        send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
        @(negedge clk);
        check("f_we_now",   32'(im_we), 32'd1);
        check("f_done_now", 32'(done),  32'd1);
        send(8'h28, 0);
        settle();
        check("f_writes",   32'(we_cnt - base), 32'd1);
        check("f_wdata",    data_log[base],     32'hDEAD_BEEF);
        check("f_done",     32'(done),          32'd1);
        check("f_cpu_hold", 32'(cpu_hold),      32'd0);
`endif

        // Word count above depth
        base = we_cnt;
        send(8'hA5, 0);
        settle();
        check("d_error_cleared", 32'(error), 32'd0);
        send(8'h01, 0); send(8'h04, 0);
        settle();
        check("d_error",    32'(error),         32'd1);
        check("d_cpu_hold", 32'(cpu_hold),      32'd1);
        check("d_writes",   32'(we_cnt - base), 32'd0);

        // Reset mid-word, then an empty frame
        base = we_cnt;
        send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
        send(8'h11, 0); send(8'h22, 0);
        rst_n = 1'b0;
        settle();
        check("e_rst_hold",  32'(cpu_hold), 32'd1);
        check("e_rst_error", 32'(error),    32'd0);
        check("e_rst_ready", 32'(rx_ready), 32'd0);
        rst_n = 1'b1;
        send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h00, 0);
`endif
        settle();
        check("e_writes",   32'(we_cnt - base), 32'd0);
        check("e_done",     32'(done),          32'd1);
        check("e_cpu_hold", 32'(cpu_hold),      32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
